// File: rtl/custom_pio_slave.sv
// custom_pio_slave: single-bit programmable output pin with a two-register bus slave
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   addr   - register select (0 = CTRL, 1 = PERIOD)
//   re, we - single-cycle read / write strobes
//   wdata  - write data
//   rdata  - registered read data
//   pio    - output pin, driven only from registered state
module custom_pio_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pio
);
  logic        out_q, out_d, blink_q, blink_d, tog_q, tog_d;
  logic [31:0] period_q, period_d, cnt_q, cnt_d, rdata_q, rdata_d;
  logic        ctrl_wr, per_wr, run, wrap;
  assign pio   = blink_q ? tog_q : out_q;
  assign rdata = rdata_q;
  always_comb begin
    ctrl_wr  = we && !addr;
    per_wr   = we && addr;
    run      = blink_q && (period_q != 32'd0);
    wrap     = cnt_q == period_q - 32'd1;
    out_d    = ctrl_wr ? wdata[0] : out_q;
    blink_d  = ctrl_wr ? wdata[1] : blink_q;
    period_d = per_wr ? wdata : period_q;
    tog_d    = (run && wrap) ? ~tog_q : tog_q;
    cnt_d    = (!run || wrap) ? 32'd0 : cnt_q + 32'd1;
    // entering blink mode starts the square wave from the newly written level
    if (ctrl_wr && !blink_q && wdata[1]) tog_d = wdata[0];
    // a period write or a blink mode change restarts the half-period count
    if (per_wr || (ctrl_wr && (blink_q != wdata[1]))) cnt_d = 32'd0;
    // reads sample pre-write state, so a same-address collision returns the old value
    rdata_d  = re ? (addr ? period_q : {29'd0, pio, blink_q, out_q}) : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q    <= 1'b0;
      blink_q  <= 1'b0;
      tog_q    <= 1'b0;
      period_q <= 32'd0;
      cnt_q    <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      out_q    <= out_d;
      blink_q  <= blink_d;
      tog_q    <= tog_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_custom_pio_slave.sv
// tb_custom_pio_slave: scoreboard bench with a time-based reference model
module tb_custom_pio_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        addr = 1'b0, re = 1'b0, we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        pio;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic        m_out = 0, m_en = 0, m_tog = 0;
  logic [31:0] m_per = 0;
  longint      cyc = 0, start = 0;
  logic        m_pio;
  logic        pio_seen;
  int          toggles;
  custom_pio_slave dut (
    .clk(clk), .reset(reset), .addr(addr), .re(re), .we(we),
    .wdata(wdata), .rdata(rdata), .pio(pio)
  );
  always #5 clk = ~clk;
  assign m_pio = m_en ? m_tog : m_out;
  // Reference: the pin inverts at every multiple of PERIOD edges after the last restart
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_out = 0; m_en = 0; m_tog = 0; m_per = 0; start = cyc;
      exp_q.push_back(32'd0);
    end else begin
      if (re) exp_q.push_back(addr ? m_per : {29'd0, m_pio, m_en, m_out});
      if (m_en && m_per != 0 && cyc > start && ((cyc - start) % longint'(m_per)) == 0)
        m_tog = ~m_tog;
      if (we && !addr) begin
        if (!m_en && wdata[1]) begin
          m_tog = wdata[0];
          start = cyc;
        end
        m_out = wdata[0];
        m_en  = wdata[1];
      end
      if (we && addr) begin
        m_per = wdata;
        start = cyc;
      end
    end
  end
  always @(negedge clk) begin
    checks++;
    if (pio !== m_pio) begin
      errors++;
      $display("FAIL pio at cycle %0d: got %b expected %b", cyc, pio, m_pio);
    end
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL rdata at cycle %0d: got %h expected %h", cyc, rdata, e);
      end
    end
  end
  task automatic drive(input logic r, input logic w, input logic a, input logic [31:0] d);
    @(negedge clk);
    re = r; we = w; addr = a; wdata = d;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 32'd0);
  endtask
  initial begin
    reset = 0; we = 1; wdata = 32'hFFFF_FFFF;
    repeat (25) @(negedge clk);
    drive(1, 0, 0, 0);
    reset = 1;
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 0);
    drive(0, 1, 0, 32'd1);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 32'd0);
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 32'd4);
    drive(0, 1, 0, 32'd2);
    idle(13);
    drive(1, 0, 1, 0);
    idle(2);
    drive(0, 1, 1, 32'd1);
    idle(5);
    drive(0, 1, 1, 32'd0);
    idle(6);
    drive(0, 1, 0, 32'd1);
    drive(1, 1, 0, 32'd0);
    drive(1, 0, 0, 0);
    drive(1, 1, 1, 32'd7);
    drive(1, 1, 0, 32'd3);
    drive(0, 1, 1, 32'd3);
    drive(0, 1, 0, 32'd2);
    idle(7);
    drive(0, 0, 0, 0);
    reset = 0;
    drive(0, 0, 0, 0);
    reset = 1;
    drive(1, 0, 1, 0);
    pio_seen = pio;
    toggles = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (pio !== pio_seen) toggles++;
    end
    checks++;
    if (toggles != 0) begin
      errors++;
      $display("FAIL post_reset_toggles: got %0d expected 0", toggles);
    end
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d;
      logic a;
      a = 1'($urandom_range(0, 1));
      d = a ? 32'($urandom_range(0, 6)) : 32'($urandom);
      drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0), a, d);
      reset = ($urandom_range(0, 99) != 0);
    end
    reset = 1;
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/custom_pio_slave.md
# custom_pio_slave

Single-bit programmable output port with a memory-mapped 32-bit register slave. A host processor writes the pin level directly, or enables an autonomous blink mode in which the pin toggles with a programmable half-period. Registers are read back through a registered read port. The block sits on the system bus between the processor-side interconnect and a board-level pin (LED or test point).

## Interface
- No parameters; data path fixed at 32 bits, address at 1 bit.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- addr  in  1  register select: 0 = CTRL, 1 = PERIOD.
- re  in  1  read strobe, one cycle per access.
- we  in  1  write strobe, one cycle per access.
- rdata  out  32  read data, registered.
- wdata  in  32  write data.
- pio  out  1  driven output pin.

## Operation
- CTRL (addr 0), write:
  - bit0 OUT = static pin level.
  - bit1 BLINK_EN.
  - bits 31:2 ignored.
- CTRL read: {29'b0, pio, BLINK_EN, OUT}.
- PERIOD (addr 1): 32-bit half-period in clk cycles; read returns the stored value.
- Static mode (BLINK_EN=0): pio = OUT.
- Blink mode (BLINK_EN=1): pio = TOG, an internal toggle flop.
- Blink counter CNT (32 bit):
  - Active when BLINK_EN=1 and PERIOD≠0.
  - Increments each cycle.
  - When CNT = PERIOD-1: CNT wraps to 0 and TOG inverts.
- PERIOD=0 with BLINK_EN=1: CNT held at 0, TOG frozen, pio holds its current level.
- PERIOD=1: TOG inverts every cycle.
- Writing CTRL with BLINK_EN rising 0→1: TOG loaded from the new OUT bit, CNT cleared.
- Writing CTRL with BLINK_EN staying 1: only OUT changes; TOG and CNT continue.
- Writing CTRL with BLINK_EN 1→0: pio returns to OUT; CNT cleared.
- Writing PERIOD: CNT cleared to 0; TOG keeps its value.
- Read with re=1: rdata captures the selected register on that edge. With re=0, rdata holds its last value.
- Strobe collisions:
  - re and we both 1, same address: write is applied; rdata returns the pre-write value.
  - re and we both 1, different addresses: both performed.
- pio is purely a function of registered state (OUT, BLINK_EN, TOG); no combinational path from bus inputs.

## Timing
- Reset (reset=0 at a rising edge): OUT=0, BLINK_EN=0, TOG=0, PERIOD=0, CNT=0, rdata=0, so pio=0.
- Reset has priority over we/re in the same cycle.
- Reset released mid-blink: state returns to the reset values above; blinking does not resume until reprogrammed.
- Write latency: register updated at the edge where we=1; pio reflects a CTRL write immediately after that edge.
- Read latency: 1 cycle. rdata is valid after the edge where re=1 and stays stable until the next read.
- Blink timing:
  - Enable edge E with PERIOD=N≥1: first TOG inversion at edge E+N, then every N edges.
  - pio square wave period = 2N cycles.
- Write to PERIOD at edge W, blinking active: next inversion at edge W+N_new.
- Strobes are single-cycle; holding we high for k cycles repeats the write k times (idempotent for PERIOD; for CTRL, only the first cycle can produce a BLINK_EN rising edge).
- No wait states; no back-pressure signal.

## Test plan
- Reset: hold reset=0 for 25 cycles with we=1, wdata=32'hFFFF_FFFF → pio=0, rdata=0; then read CTRL and PERIOD → both 0.
- Static write: we=1, addr=0, wdata=1 → pio=1 after that edge; read CTRL → rdata=32'h5. Write wdata=0 → pio=0, CTRL reads 32'h0.
- Blink: write PERIOD=4, then CTRL=32'h2 at edge E → pio=0, inverting at E+4, E+8, E+12…; read PERIOD → 32'h4.
- Retime: during blink with PERIOD=4, write PERIOD=1 at edge W → pio inverts at W+1 and every cycle thereafter. Write PERIOD=0 → pio frozen.
- Collision: CTRL=1, then re=we=1, addr=0, wdata=0 in one cycle → rdata=32'h5 (old value), pio=0 after that edge.
- Mid-operation reset: blinking with PERIOD=3, assert reset=0 for one edge → pio=0, PERIOD read back 0, no further toggles.
